// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue
//   Takes decoded PS/2 bytes from the receiver and strips the break (F0) and
//   extended (E0) prefixes. It tracks Shift (left/right) and Caps Lock. Each
//   printable make code is queued as {letter_case, scan_code} in a small FIFO
//   for the scan-code-to-ASCII converter.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   rx_done_tick       one-cycle strobe, rx_data holds a complete byte
//   rx_data[7:0]       received PS/2 byte
//   rd                 pop request (ignored when empty)
//   empty, full        FIFO status
//   scan_code[7:0]     head entry scan code (0 when empty)
//   letter_case        head entry case bit, 1 = upper (0 when empty)
//   caps_on            Caps Lock toggle state for the LED path
//   overflow           sticky: an event was dropped on a full FIFO
module ps2_key_event_queue #(
    parameter int DEPTH_BITS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rd,
    output logic       empty,
    output logic       full,
    output logic [7:0] scan_code,
    output logic       letter_case,
    output logic       caps_on,
    output logic       overflow
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   shift_l_q, shift_l_d;
    logic   shift_r_q, shift_r_d;
    logic   caps_held_q, caps_held_d;
    logic   caps_on_q, caps_on_d;
    logic   overflow_q, overflow_d;

    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic [8:0]            mem_q [DEPTH];

    logic       push_req;
    logic       do_push;
    logic       do_pop;
    logic [8:0] push_data;
    logic [8:0] head;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);

    // Byte decoder. Only make codes seen from IDLE can request a push.
    always_comb begin
        state_d     = state_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        caps_held_d = caps_held_q;
        caps_on_d   = caps_on_q;
        push_req    = 1'b0;
        if (rx_done_tick) begin
            unique case (state_q)
                IDLE: begin
                    unique case (rx_data)
                        8'hF0: state_d = BRK;
                        8'hE0: state_d = EXT;
                        8'h12: shift_l_d = 1'b1;
                        8'h59: shift_r_d = 1'b1;
                        8'h58: begin
                            // Toggle only on the first make; auto-repeat of a
                            // held Caps Lock key must not flip it again.
                            if (!caps_held_q) caps_on_d = ~caps_on_q;
                            caps_held_d = 1'b1;
                        end
                        8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE: ;
                        default: push_req = 1'b1;
                    endcase
                end
                BRK: begin
                    unique case (rx_data)
                        8'h12:   shift_l_d   = 1'b0;
                        8'h59:   shift_r_d   = 1'b0;
                        8'h58:   caps_held_d = 1'b0;
                        default: ;
                    endcase
                    state_d = IDLE;
                end
                EXT:     state_d = (rx_data == 8'hF0) ? EXT_BRK : IDLE;
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign push_data = {(shift_l_q | shift_r_q) ^ caps_on_q, rx_data};

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds when rd is asserted alongside it.
    assign do_pop  = rd & ~empty;
    assign do_push = push_req & (~full | do_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_req & full & ~do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (DEPTH_BITS + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_BITS + 1)'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            caps_held_q <= 1'b0;
            caps_on_q   <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            caps_held_q <= caps_held_d;
            caps_on_q   <= caps_on_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q says so.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head        = mem_q[rd_ptr_q];
    assign scan_code   = empty ? 8'h00 : head[7:0];
    assign letter_case = empty ? 1'b0  : head[8];
    assign caps_on     = caps_on_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/ps2_key_event_queue.md
Name: ps2_key_event_queue

Overview:
- Sits between the PS/2 receiver (byte + done tick) and the scan-code-to-ASCII converter.
- Strips break (F0) and extended (E0) prefixes and tracks the Shift and Caps Lock state.
- Queues each printable key "make" event as a {letter_case, scan_code} pair in a small FIFO.
- The downstream converter/consumer pops events with a read strobe. Auto-repeat makes pass through, so held keys repeat.

Parameters:
- DEPTH_BITS, 2, log2 of FIFO depth (default 4 entries); legal range 1..6.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_done_tick  in  1  one-cycle strobe: rx_data holds a complete PS/2 byte.
- rx_data  in  8  received PS/2 byte; valid only when rx_done_tick=1.
- rd  in  1  pop request; ignored when empty=1.
- empty  out  1  FIFO holds no events.
- full  out  1  FIFO holds 2^DEPTH_BITS events.
- scan_code  out  8  scan code of the head entry; 8'h00 when empty.
- letter_case  out  1  case bit of the head entry (1 = upper); 0 when empty.
- caps_on  out  1  Caps Lock toggle state, for the keyboard LED path.
- overflow  out  1  sticky: at least one event was dropped because the FIFO was full.

Behaviour:
- Reset (reset_n=0, async): FSM=IDLE, FIFO pointers=0, empty=1, full=0, scan_code=0, letter_case=0, caps_on=0, overflow=0, shift_l=shift_r=caps_held=0.
- Bytes are processed only in cycles with rx_done_tick=1; otherwise the FSM and flags hold.
- shift = shift_l | shift_r. Case bit pushed = shift ^ caps_on, sampled in the same cycle as the make byte.
- FSM states: IDLE, BRK, EXT, EXT_BRK.
- IDLE, byte:
  - F0 -> BRK.
  - E0 -> EXT.
  - 12 -> shift_l=1, no push.
  - 59 -> shift_r=1, no push.
  - 58 -> if caps_held=0, toggle caps_on; caps_held=1; no push.
  - 00, FF, AA, FA, FE, EE -> discarded (error/BAT/ack codes).
  - Any other byte -> push {case, byte}; stay IDLE.
- BRK, byte:
  - 12 -> shift_l=0.
  - 59 -> shift_r=0.
  - 58 -> caps_held=0.
  - Any other byte -> no effect.
  - Always -> IDLE. A break never pushes.
- EXT, byte: F0 -> EXT_BRK; any other byte discarded (extended keys, including E0 12 fake-shift, are not forwarded) -> IDLE.
- EXT_BRK: any byte discarded -> IDLE.
- FIFO structure: 2^DEPTH_BITS entries x 9 bits; write/read pointers DEPTH_BITS wide and wrap modulo depth. Count (or an extra pointer bit) distinguishes full from empty.
- FIFO push/pop rules:
  - Push while full with no pop in the same cycle: the event is dropped, overflow=1 (sticky until reset), and the FIFO is unchanged.
  - Push and pop (rd=1, empty=0) in the same cycle: both succeed and the count is unchanged. This holds when full as well, so no drop occurs.
  - Pop when empty: no effect.
- Latency: make byte with tick in cycle N -> empty=0 and head visible at the outputs after edge N+1. Pop in cycle M -> next head (or empty=1) after edge M+1.
- Output timing: scan_code and letter_case reflect the head entry combinationally from the FIFO read pointer and are forced to 0 when empty. The consumer samples them when empty=0, then asserts rd.
- Reset mid-sequence (e.g., after F0 with the next byte pending): everything returns to reset values; the pending byte is then interpreted from IDLE.
- Ticks on consecutive cycles are each processed; no minimum spacing is required.

Test Plan:
- Byte 1C, 1C (held-key auto-repeat) then F0 1C, no rd -> two entries {0,8'h1C}; after pops, empty=1; break pushes nothing.
- 12, 1C, F0 12, 1C -> entries {1,1C} then {0,1C}; shift_r path: 59, 32, F0 59 -> {1,32}.
- 58, 58, F0 58, 1C, then 58, F0 58, 12, 1C:
  - after the first make caps_on=1 (the repeat does not re-toggle); entry {1,1C};
  - after the second toggle caps_on=0; shift held gives {1,1C};
  - repeat with shift and caps both on -> {0,1C}.
- E0 75, E0 F0 75, then 29 -> only entry {0,29}; FSM back in IDLE after each sequence.
- With DEPTH_BITS=2:
  - push 16,1E,26,25 -> full=1; push 2E -> overflow=1, contents unchanged;
  - with full, rd=1 in the same cycle as push 36 -> full stays 1, head becomes 1E, tail 36.
- Send F0, assert reset_n=0 for 1 cycle, then send 1C -> entry {0,1C} pushed (not treated as break); all outputs 0 during reset.
